// File: rtl/pux_sdemux.sv
// Packed-frame stream demultiplexer: header word, then N words each for operands A, B and M.
// Define PUX_SDEMUX_LASTCHK_EN to compile in axis_in_last framing checks (codes 10/11).
module pux_sdemux #(
  parameter int OPCW  = 8,
  parameter int DATAW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stream_request,
  input  logic [DATAW-1:0] axis_in_data,
  input  logic             axis_in_valid,
  input  logic             axis_in_last,
  output logic             axis_in_ready,
  output logic [OPCW-1:0]  axis_opcode_data,
  output logic             axis_opcode_valid,
  input  logic             axis_opcode_ready,
  output logic [DATAW-1:0] axis_abuff_data,
  output logic             axis_abuff_valid,
  input  logic             axis_abuff_ready,
  output logic [DATAW-1:0] axis_bbuff_data,
  output logic             axis_bbuff_valid,
  input  logic             axis_bbuff_ready,
  output logic [DATAW-1:0] axis_mbuff_data,
  output logic             axis_mbuff_valid,
  input  logic             axis_mbuff_ready,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [2:0]       dbg_state
);
  // Handshakes: a word moves on a rising edge where valid and ready are both high;
  // valid never waits on ready, and operand-phase ready mirrors the active sink.
  localparam int LENW = DATAW - OPCW;
  localparam logic [LENW-1:0] ONE = {{(LENW-1){1'b0}}, 1'b1};
  localparam logic [LENW-1:0] ZERO = '0;
`ifdef PUX_SDEMUX_LASTCHK_EN
  localparam bit LASTCHK = 1'b1;
`else
  localparam bit LASTCHK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HDR = 3'd1, S_OPC = 3'd2, S_A = 3'd3,
    S_B = 3'd4, S_M = 3'd5, S_DRAIN = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic [LENW-1:0] cnt, cnt_nxt, len_r, len_nxt;
  logic [OPCW-1:0] opc_r, opc_nxt;
  logic            err_nxt;
  logic [1:0]      code_nxt;
  logic            hs, final_beat;

  assign hs         = axis_in_valid && axis_in_ready;
  assign final_beat = (state == S_M) && (cnt == ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      len_r    <= '0;
      opc_r    <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      len_r    <= len_nxt;
      opc_r    <= opc_nxt;
      err      <= err_nxt;
      err_code <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_r;
    opc_nxt   = opc_r;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    case (state)
      S_IDLE: if (stream_request) state_nxt = S_HDR;
      S_HDR: begin
        if (hs) begin
          opc_nxt = axis_in_data[OPCW-1:0];
          len_nxt = axis_in_data[DATAW-1:OPCW];
          if (axis_in_data[DATAW-1:OPCW] == ZERO) begin
            err_nxt   = 1'b1;
            code_nxt  = 2'b01;
            state_nxt = axis_in_last ? S_IDLE : S_DRAIN;
          end else if (LASTCHK && axis_in_last) begin
            err_nxt   = 1'b1;
            code_nxt  = 2'b10;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_OPC;
          end
        end
      end
      S_OPC: begin
        if (axis_opcode_ready) begin
          state_nxt = S_A;
          cnt_nxt   = len_r - ONE;
        end
      end
      S_A, S_B, S_M: begin
        if (hs) begin
          if (LASTCHK && axis_in_last && !final_beat) begin
            err_nxt   = 1'b1;
            code_nxt  = 2'b10;
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else if (LASTCHK && !axis_in_last && final_beat) begin
            err_nxt   = 1'b1;
            code_nxt  = 2'b11;
            state_nxt = S_DRAIN;
          end else if (cnt == ZERO) begin
            // Reload for the next operand; M finishing returns to IDLE.
            cnt_nxt = (state == S_M) ? ZERO : len_r - ONE;
            case (state)
              S_A:     state_nxt = S_B;
              S_B:     state_nxt = S_M;
              default: state_nxt = S_IDLE;
            endcase
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
      end
      S_DRAIN: if (hs && axis_in_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is held, even before the state register clears.
  always_comb begin
    axis_in_ready     = 1'b0;
    axis_opcode_valid = 1'b0;
    axis_abuff_valid  = 1'b0;
    axis_bbuff_valid  = 1'b0;
    axis_mbuff_valid  = 1'b0;
    if (!rst) begin
      case (state)
        S_HDR, S_DRAIN: axis_in_ready = 1'b1;
        S_OPC: axis_opcode_valid = 1'b1;
        S_A: begin
          axis_in_ready    = axis_abuff_ready;
          axis_abuff_valid = axis_in_valid;
        end
        S_B: begin
          axis_in_ready    = axis_bbuff_ready;
          axis_bbuff_valid = axis_in_valid;
        end
        S_M: begin
          axis_in_ready    = axis_mbuff_ready;
          axis_mbuff_valid = axis_in_valid;
        end
        default: ;
      endcase
    end
  end

  assign axis_opcode_data = opc_r;
  assign axis_abuff_data  = axis_in_data;
  assign axis_bbuff_data  = axis_in_data;
  assign axis_mbuff_data  = axis_in_data;
  assign busy             = (state != S_IDLE);
  assign dbg_state        = state;
endmodule

// File: tb/tb_pux_sdemux.sv
// Scoreboard bench for pux_sdemux: directed frames, expected beats queued at issue and checked by a monitor.
module tb_pux_sdemux;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stream_request = 1'b0;
  logic [15:0] axis_in_data = '0;
  logic        axis_in_valid = 1'b0;
  logic        axis_in_last = 1'b0;
  logic        axis_in_ready;
  logic [7:0]  axis_opcode_data;
  logic        axis_opcode_valid;
  logic        axis_opcode_ready = 1'b1;
  logic [15:0] axis_abuff_data, axis_bbuff_data, axis_mbuff_data;
  logic        axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid;
  logic        axis_abuff_ready = 1'b1, axis_bbuff_ready = 1'b1, axis_mbuff_ready = 1'b1;
  logic        busy, err;
  logic [1:0]  err_code;
  logic [2:0]  dbg_state;

  logic [17:0] exp_q[$];
  logic [1:0]  err_q[$];
  int n_checks = 0;
  int n_pass = 0;

  pux_sdemux #(.OPCW(8), .DATAW(16)) dut (
    .clk(clk), .rst(rst), .stream_request(stream_request),
    .axis_in_data(axis_in_data), .axis_in_valid(axis_in_valid),
    .axis_in_last(axis_in_last), .axis_in_ready(axis_in_ready),
    .axis_opcode_data(axis_opcode_data), .axis_opcode_valid(axis_opcode_valid),
    .axis_opcode_ready(axis_opcode_ready),
    .axis_abuff_data(axis_abuff_data), .axis_abuff_valid(axis_abuff_valid),
    .axis_abuff_ready(axis_abuff_ready),
    .axis_bbuff_data(axis_bbuff_data), .axis_bbuff_valid(axis_bbuff_valid),
    .axis_bbuff_ready(axis_bbuff_ready),
    .axis_mbuff_data(axis_mbuff_data), .axis_mbuff_valid(axis_mbuff_valid),
    .axis_mbuff_ready(axis_mbuff_ready),
    .busy(busy), .err(err), .err_code(err_code), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: act=%0h req=%0h", name, act, exp);
  endtask

  task automatic pop_cmp(input string name, input logic [17:0] got);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s unexpected beat: act=%0h req=none", name, got);
    end else begin
      check(name, 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (axis_opcode_valid && axis_opcode_ready) pop_cmp("opcode", {2'd0, 8'h00, axis_opcode_data});
      if (axis_abuff_valid && axis_abuff_ready) pop_cmp("abuff", {2'd1, axis_abuff_data});
      if (axis_bbuff_valid && axis_bbuff_ready) pop_cmp("bbuff", {2'd2, axis_bbuff_data});
      if (axis_mbuff_valid && axis_mbuff_ready) pop_cmp("mbuff", {2'd3, axis_mbuff_data});
      if (err) begin
        if (err_q.size() == 0) begin
          n_checks++;
          $display("FAIL err unexpected pulse: act=%0d req=none", err_code);
        end else begin
          check("err_code", 32'(err_code), 32'(err_q.pop_front()));
        end
      end
    end
  end

  // drivers
  task automatic send_word(input logic [15:0] d, input logic l);
    bit done = 0;
    axis_in_data  = d;
    axis_in_last  = l;
    axis_in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #1;
      if (axis_in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_word timeout: act=stuck req=accept data=%0h", d);
    end
    axis_in_valid = 1'b0;
    axis_in_last  = 1'b0;
  endtask

  task automatic start_req;
    @(posedge clk);
    #1 stream_request = 1'b1;
    @(posedge clk);
    #1 stream_request = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] opc, input logic [7:0] n);
    exp_q.push_back({2'd0, 8'h00, opc});
    send_word({n, opc}, 1'b0);
    for (int i = 1; i <= n; i++) begin
      exp_q.push_back({2'd1, 16'hA000 + 16'(i)});
      send_word(16'hA000 + 16'(i), 1'b0);
    end
    for (int i = 1; i <= n; i++) begin
      exp_q.push_back({2'd2, 16'hB000 + 16'(i)});
      send_word(16'hB000 + 16'(i), 1'b0);
    end
    for (int i = 1; i <= n; i++) begin
      exp_q.push_back({2'd3, 16'hC000 + 16'(i)});
      send_word(16'hC000 + 16'(i), i == n);
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(axis_in_ready), 0);
    check("rst_opc_valid", 32'(axis_opcode_valid), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_state", 32'(dbg_state), 0);
    check("idle_in_ready", 32'(axis_in_ready), 0);

    // basic N=2 frame
    start_req;
    check("hdr_busy", 32'(busy), 1);
    check("hdr_state", 32'(dbg_state), 1);
    send_frame(8'h5A, 8'd2);
    check("basic_busy_after", 32'(busy), 0);

    // A2 stalled for 3 cycles
    start_req;
    exp_q.push_back({2'd0, 8'h00, 8'h5A});
    send_word(16'h025A, 1'b0);
    exp_q.push_back({2'd1, 16'hA001});
    send_word(16'hA001, 1'b0);
    axis_abuff_ready = 1'b0;
    exp_q.push_back({2'd1, 16'hA002});
    fork
      send_word(16'hA002, 1'b0);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(axis_in_ready), 0);
          check("stall_hold", 32'({axis_abuff_valid, axis_abuff_data}), 32'({1'b1, 16'hA002}));
        end
        @(posedge clk);
        #1 axis_abuff_ready = 1'b1;
      end
    join
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back({2'd2, 16'hB000 + 16'(i)});
      send_word(16'hB000 + 16'(i), 1'b0);
    end
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back({2'd3, 16'hC000 + 16'(i)});
      send_word(16'hC000 + 16'(i), i == 2);
    end
    check("stall_busy_after", 32'(busy), 0);
    check("stall_queue_empty", 32'(exp_q.size()), 0);

    // zero-length header, then drain
    start_req;
    err_q.push_back(2'b01);
    send_word(16'h0033, 1'b0);
    check("zl_drain_state", 32'(dbg_state), 6);
    send_word(16'hDEAD, 1'b0);
    check("zl_still_busy", 32'(busy), 1);
    send_word(16'hBEEF, 1'b1);
    check("zl_idle", 32'(busy), 0);
    check("zl_code_held", 32'(err_code), 1);

`ifdef PUX_SDEMUX_LASTCHK_EN
    // early last on B2
    start_req;
    exp_q.push_back({2'd0, 8'h00, 8'h11});
    send_word(16'h0311, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back({2'd1, 16'hA000 + 16'(i)});
      send_word(16'hA000 + 16'(i), 1'b0);
    end
    exp_q.push_back({2'd2, 16'hB001});
    send_word(16'hB001, 1'b0);
    exp_q.push_back({2'd2, 16'hB002});
    err_q.push_back(2'b10);
    send_word(16'hB002, 1'b1);
    check("early_last_idle", 32'(busy), 0);
    @(negedge clk);
    check("early_last_code", 32'(err_code), 2);
`endif

    // reset during M phase of N=4, then N=1 frame
    start_req;
    exp_q.push_back({2'd0, 8'h00, 8'h77});
    send_word(16'h0477, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({2'd1, 16'hA000 + 16'(i)});
      send_word(16'hA000 + 16'(i), 1'b0);
    end
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({2'd2, 16'hB000 + 16'(i)});
      send_word(16'hB000 + 16'(i), 1'b0);
    end
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back({2'd3, 16'hC000 + 16'(i)});
      send_word(16'hC000 + 16'(i), 1'b0);
    end
    rst = 1'b1;
    axis_in_data  = 16'hC003;
    axis_in_valid = 1'b1;
    @(negedge clk);
    check("mrst_in_ready", 32'(axis_in_ready), 0);
    check("mrst_mvalid", 32'(axis_mbuff_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    axis_in_valid = 1'b0;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_state", 32'(dbg_state), 0);
    check("mrst_err_code", 32'(err_code), 0);
    @(negedge clk);
    check("mrst_no_resume", 32'(busy), 0);
    start_req;
    send_frame(8'h42, 8'd1);
    check("post_rst_idle", 32'(busy), 0);

    // request held across back-to-back frames
    @(posedge clk);
    #1 stream_request = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'h01, 8'd1);
    check("b2b_idle", 32'(busy), 0);
    @(posedge clk);
    #1;
    check("b2b_hdr_next", 32'(dbg_state), 1);
    send_frame(8'h02, 8'd1);
    stream_request = 1'b0;
    check("b2b_idle2", 32'(busy), 0);

    // request pulse while busy is ignored
    start_req;
    exp_q.push_back({2'd0, 8'h00, 8'h03});
    send_word(16'h0103, 1'b0);
    stream_request = 1'b1;
    exp_q.push_back({2'd1, 16'hA001});
    send_word(16'hA001, 1'b0);
    stream_request = 1'b0;
    exp_q.push_back({2'd2, 16'hB001});
    send_word(16'hB001, 1'b0);
    exp_q.push_back({2'd3, 16'hC001});
    send_word(16'hC001, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("pulse_ignored", 32'(busy), 0);

    repeat (3) @(posedge clk);
    check("final_exp_empty", 32'(exp_q.size()), 0);
    check("final_err_empty", 32'(err_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pux_sdemux.md
PUX_SDEMUX -- requirements
Module: pux_sdemux

Interface
REQ-001 Parameter OPCW, default 8: opcode width in bits.
REQ-002 Parameter DATAW, default 16: stream word width in bits; LENW = DATAW-OPCW is the length-field width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stream_request  input  1  fetch request from the downstream stream interface; level-sampled in IDLE.
REQ-006 axis_in_data / axis_in_valid / axis_in_last / axis_in_ready  in/in/in/out  DATAW/1/1/1  packed frame input stream.
REQ-007 axis_opcode_data / axis_opcode_valid / axis_opcode_ready  out/out/in  OPCW/1/1  opcode stream to the stream interface.
REQ-008 axis_abuff_*, axis_bbuff_*, axis_mbuff_* (data out DATAW, valid out 1, ready in 1)  operand streams A, B, M.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 err  output  1  one-cycle error pulse.
REQ-011 err_code  output  2  01 = zero length, 10 = early last, 11 = missing last; held until the next err.

Function
REQ-012 Frame format: word0 header, opcode = [OPCW-1:0] and N = [DATAW-1:OPCW]; then N A-words, N B-words, N M-words.
REQ-013 FSM states: IDLE, HDR, OPC, A, B, M, DRAIN.
REQ-014 IDLE: axis_in_ready=0; on stream_request=1, next state is HDR.
REQ-015 HDR: axis_in_ready=1; on handshake, register opcode and N and go to OPC; if N=0, pulse err with code 01 and go to DRAIN, or to IDLE if axis_in_last=1.
REQ-016 OPC: axis_opcode_valid=1 with the registered opcode, axis_in_ready=0; on axis_opcode_ready, go to A.
REQ-017 A/B/M pass-through, zero latency: out_data=axis_in_data, out_valid=axis_in_valid, axis_in_ready=out_ready of the active stream only; all other valids are 0.
REQ-018 The beat counter (LENW bits) loads N-1 on entry to A/B/M and decrements per handshake; at 0 with a handshake, go A->B, B->M, M->IDLE.
REQ-019 stream_request while busy is ignored; no queued request.
REQ-020 Max frame: N=2^LENW-1; the counter never wraps within an operand.
REQ-021 DRAIN: axis_in_ready=1, all output valids 0; data is discarded until a handshake with axis_in_last=1, then go to IDLE.
REQ-022 err is registered: it asserts the cycle after the detecting handshake.

Reset
REQ-023 rst=1 forces IDLE on the next edge from any state; counter=0, opcode/N registers=0, err=0, err_code=00, busy=0.
REQ-024 During and after reset, all *_valid outputs and axis_in_ready are 0; a partial frame is abandoned and not resumed.

Configuration
REQ-025 Macro PUX_SDEMUX_LASTCHK_EN compiles in axis_in_last checking.
REQ-026 When defined: axis_in_last=1 on any beat before the final M beat completes that beat, pulses err code 10, and goes to IDLE. axis_in_last=0 on the final M beat pulses err code 11 and goes to DRAIN.
REQ-027 When undefined: axis_in_last is ignored outside DRAIN, codes 10/11 never occur, and the frame ends on counter alone; the zero-length check remains.

Verification
REQ-028 N=2, opcode 0x5A, words A1 A2 B1 B2 M1 M2 with last on M2, all readies=1 -> opcode 0x5A once, then 2 beats each on A/B/M in order; busy falls the cycle after M2; err never asserts.
REQ-029 Same frame with axis_abuff_ready low for 3 cycles on A2 -> A2 held on the output, axis_in_ready=0 for those 3 cycles; no beat lost or duplicated.
REQ-030 Header with N=0 and last=0, then 2 junk words, last on the 2nd -> err pulse with code 01; no output valids; IDLE after the 2nd junk word.
REQ-031 LASTCHK_EN defined, N=3, last on B2 -> err code 10, IDLE; the B stream carried 2 beats; the M stream carried none.
REQ-032 rst=1 for 1 cycle during the M phase of N=4, then a new request and an N=1 frame -> clean IDLE, then a correct 1-beat A/B/M transfer.
REQ-033 stream_request held high across back-to-back frames -> second HDR is entered the cycle after first IDLE; request pulses during busy have no effect.
